// File: rtl/seq_mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier: state encoding and
// a two's-complement magnitude helper sized for the widest supported operand.
package seq_mult_pkg;

  localparam int MAX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Callers zero-extend into MAX_W bits and keep only their own low bits.
  function automatic logic [MAX_W-1:0] twos_mag(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/seq_mult_param_if.sv
// Operand/result bundle between the board inputs and the multiplier core.
interface seq_mult_param_if #(
  parameter int WIDTH = 8
) ();
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   multiplier_in;
  logic [WIDTH-1:0]   multiplicand_in;
  logic               busy;
  logic               valid;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, signed_mode, multiplier_in, multiplicand_in,
    input  busy, valid, product
  );

  modport slave (
    input  start, signed_mode, multiplier_in, multiplicand_in,
    output busy, valid, product
  );
endinterface

// File: rtl/start_edge_detect.sv
// Turns a push-button level into a one-cycle pulse on each press edge.
module start_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic pulse_out
);
  localparam logic IDLE_LVL = ACTIVE_LOW;

  logic lvl_d1_q, lvl_d2_q;

  // Reset to the released level so a button already idle cannot fake a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_d1_q <= IDLE_LVL;
      lvl_d2_q <= IDLE_LVL;
    end else begin
      lvl_d1_q <= level_in;
      lvl_d2_q <= lvl_d1_q;
    end
  end

  assign pulse_out = (lvl_d1_q != IDLE_LVL) && (lvl_d2_q == IDLE_LVL);
endmodule

// File: rtl/seq_mult_param.sv
// Iterative shift-add multiplier: one partial-product step per cycle on operand
// magnitudes, sign restored in a final fix-up cycle.
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int WIDTH            = 8,
  parameter bit START_ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  seq_mult_param_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 valid_q, valid_d;

  logic                 start_on;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       sum;

  start_edge_detect #(.ACTIVE_LOW(START_ACTIVE_LOW)) u_start (
    .clk      (clk),
    .rst      (rst),
    .level_in (bus.start),
    .pulse_out(start_on)
  );

  assign a_neg = bus.signed_mode & bus.multiplier_in[WIDTH-1];
  assign b_neg = bus.signed_mode & bus.multiplicand_in[WIDTH-1];
  assign mag_a = WIDTH'(twos_mag(MAX_W'(bus.multiplier_in), a_neg));
  assign mag_b = WIDTH'(twos_mag(MAX_W'(bus.multiplicand_in), b_neg));
  // One spare bit so the carry drops into the accumulator msb on the shift.
  assign sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    valid_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_on) begin
          acc_d   = {{WIDTH{1'b0}}, mag_a};
          mcand_d = mag_b;
          // A zero operand never gets negated.
          neg_d   = (a_neg ^ b_neg) & (|bus.multiplier_in) & (|bus.multiplicand_in);
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        product_d = neg_q ? (~acc_q + 1'b1) : acc_q;
        valid_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.valid   = valid_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench: an 8-bit active-low-start instance and a 4-bit active-high
// instance checked against integer-arithmetic products.
module tb_seq_mult_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] q8[$];
  logic [7:0]  q4[$];
  logic        v8_prev = 1'b0, v4_prev = 1'b0;

  seq_mult_param_if #(.WIDTH(8)) if8 ();
  seq_mult_param_if #(.WIDTH(4)) if4 ();

  seq_mult_param #(.WIDTH(8), .START_ACTIVE_LOW(1'b1)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  seq_mult_param #(.WIDTH(4), .START_ACTIVE_LOW(1'b0)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mul(input int w, input logic sm, input logic [15:0] a,
                                          input logic [15:0] b);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 16'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic set_start(input int w, input logic pressed);
    if (w == 8) if8.start = ~pressed;
    else        if4.start = pressed;
  endtask

  task automatic drive_ops(input int w, input logic sm, input logic [15:0] a, input logic [15:0] b);
    if (w == 8) begin
      if8.signed_mode = sm; if8.multiplier_in = a[7:0]; if8.multiplicand_in = b[7:0];
    end else begin
      if4.signed_mode = sm; if4.multiplier_in = a[3:0]; if4.multiplicand_in = b[3:0];
    end
  endtask

  function automatic logic get_v(input int w);
    return (w == 8) ? if8.valid : if4.valid;
  endfunction

  function automatic logic get_b(input int w);
    return (w == 8) ? if8.busy : if4.busy;
  endfunction

  // Press, expect the result, and check latency/busy span; operands are
  // scrambled after capture to show they no longer matter.
  task automatic run_op(input int w, input logic sm, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp);
    int k = 0, nbusy = 0;
    logic seen = 1'b0;
    @(negedge clk);
    drive_ops(w, sm, a, b);
    if (w == 8) q8.push_back(exp);
    else        q4.push_back(exp[7:0]);
    set_start(w, 1'b1);
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 3) drive_ops(w, $urandom_range(0, 1), 16'($urandom), 16'($urandom));
      if (get_b(w)) nbusy++;
      if (get_v(w)) seen = 1'b1;
    end
    chk("valid_timeout", 32'(seen), 32'd1);
    chk("latency", k, w + 3);
    chk("busy_cycles", nbusy, w + 1);
    set_start(w, 1'b0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (if8.valid) begin
        chk("pulse8_width", 32'(v8_prev), 32'd0);
        if (q8.size() == 0) chk("stray_valid8", 32'd1, 32'd0);
        else chk("product8", 32'(if8.product), 32'(q8.pop_front()));
      end
      if (if4.valid) begin
        chk("pulse4_width", 32'(v4_prev), 32'd0);
        if (q4.size() == 0) chk("stray_valid4", 32'd1, 32'd0);
        else chk("product4", 32'(if4.product), 32'(q4.pop_front()));
      end
    end
    v8_prev = if8.valid;
    v4_prev = if4.valid;
  end

  initial begin
    int k, m, nv;
    logic seen;
    logic sm;
    logic [15:0] a, b;

    if8.start = 1'b1; if4.start = 1'b0;
    drive_ops(8, 1'b0, 16'd0, 16'd0);
    drive_ops(4, 1'b0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy8", 32'(if8.busy), 32'd0);
    chk("rst_valid8", 32'(if8.valid), 32'd0);
    chk("rst_prod8", 32'(if8.product), 32'd0);
    chk("rst_busy4", 32'(if4.busy), 32'd0);
    chk("rst_prod4", 32'(if4.product), 32'd0);

    run_op(4, 1'b0, 16'd15, 16'd15, 16'h00E1);
    run_op(8, 1'b1, 16'h00FD, 16'h0005, 16'hFFF1);
    run_op(8, 1'b1, 16'h0080, 16'h0080, 16'h4000);
    run_op(8, 1'b1, 16'h007F, 16'h0080, 16'hC080);
    run_op(8, 1'b0, 16'h00FD, 16'h0005, 16'h04F1);
    run_op(8, 1'b1, 16'h0000, 16'h00FF, 16'h0000);

    // Held press plus a second press edge during CALC: one result only.
    @(negedge clk);
    drive_ops(8, 1'b0, 16'd12, 16'd11);
    q8.push_back(ref_mul(8, 1'b0, 16'd12, 16'd11));
    set_start(8, 1'b1);
    nv = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (i == 3) set_start(8, 1'b0);
      if (i == 4) set_start(8, 1'b1);
      if (if8.valid) nv++;
    end
    chk("hold_one_valid", nv, 1);
    chk("hold_product", 32'(if8.product), 32'h0084);
    set_start(8, 1'b0);
    @(negedge clk);

    // Reset during CALC discards the operation.
    @(negedge clk);
    drive_ops(8, 1'b1, 16'h0055, 16'h0033);
    set_start(8, 1'b1);
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", 32'(if8.busy), 32'd1);
    rst = 1'b1;
    set_start(8, 1'b0);
    @(negedge clk);
    chk("abort_busy", 32'(if8.busy), 32'd0);
    chk("abort_valid", 32'(if8.valid), 32'd0);
    chk("abort_prod", 32'(if8.product), 32'd0);
    rst = 1'b0;
    run_op(8, 1'b0, 16'd6, 16'd7, 16'h002A);

    // Back-to-back: second press lands in the cycle the first valid is high.
    @(negedge clk);
    drive_ops(8, 1'b1, 16'h00F9, 16'h000B);
    q8.push_back(ref_mul(8, 1'b1, 16'h00F9, 16'h000B));
    set_start(8, 1'b1);
    k = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 3) set_start(8, 1'b0);
      if (k == 10) begin
        drive_ops(8, 1'b0, 16'h00C8, 16'h00D3);
        q8.push_back(ref_mul(8, 1'b0, 16'h00C8, 16'h00D3));
        set_start(8, 1'b1);
      end
      if (if8.valid) seen = 1'b1;
    end
    chk("b2b_lat1", k, 11);
    m = 0; seen = 1'b0;
    while (!seen && m < 40) begin
      @(negedge clk);
      m++;
      if (m == 3) set_start(8, 1'b0);
      if (if8.valid) seen = 1'b1;
    end
    // Capture one edge after the first valid, then WIDTH+1 edges to the result.
    chk("b2b_lat2", m, 10);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      sm = 1'($urandom_range(0, 1));
      a  = 16'($urandom_range(0, 255));
      b  = 16'($urandom_range(0, 255));
      run_op(8, sm, a, b, ref_mul(8, sm, a, b));
    end
    for (int i = 0; i < 8; i++) begin
      sm = 1'($urandom_range(0, 1));
      a  = 16'($urandom_range(0, 15));
      b  = 16'($urandom_range(0, 15));
      run_op(4, sm, a, b, ref_mul(4, sm, a, b));
    end

    // Idle after reset: no valid at all.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (100) begin
      @(negedge clk);
      if (if8.valid || if4.valid) nv++;
    end
    chk("idle_no_valid", nv, 0);

    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
